// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter (edge- or center-aligned),
// double-buffered period/mode/duty shadows reloaded at period boundaries, and per-channel
// duty-source select and output polarity. All outputs are registered.
module pwm_multi_ch #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4
) (
  input  logic                 chosen_clk,
  input  logic                 rst,
  input  logic                 pwm_en,
  input  logic                 center_mode,
  input  logic [WIDTH-1:0]     period_reg,
  input  logic [NCH*WIDTH-1:0] DC_reg,
  input  logic [NCH*WIDTH-1:0] i_DC,
  input  logic [NCH-1:0]       DC_sel,
  input  logic [NCH-1:0]       polarity,
  output logic [WIDTH-1:0]     counter,
  output logic                 period_end,
  output logic [NCH-1:0]       pwm
);

  // Shadow (active) copies of the programmable values
  logic [WIDTH-1:0] period_s;
  logic             mode_s;
  logic [WIDTH-1:0] duty_s [NCH];
  logic             dir_down;

  // Next-state values
  logic [WIDTH-1:0] period_n;
  logic             mode_n;
  logic [WIDTH-1:0] duty_n [NCH];
  logic [WIDTH-1:0] counter_n;
  logic             dir_down_n;
  logic             period_end_n;
  logic [NCH-1:0]   pwm_n;
  logic             load;
  logic [WIDTH-1:0] last;

  // True when a counter position is the final cycle of a period
  function automatic logic is_end(input logic [WIDTH-1:0] cnt, input logic down,
                                  input logic [WIDTH-1:0] p, input logic center);
    if (p == '0) begin
      return 1'b0;
    end
    if (center) begin
      return down && (cnt == '0);
    end
    return cnt == WIDTH'(p - 1'b1);
  endfunction

  // Shadow reload, counter stepping, boundary flag and compare outputs
  always_comb begin
    period_n     = period_s;
    mode_n       = mode_s;
    duty_n       = duty_s;
    counter_n    = '0;
    dir_down_n   = 1'b0;
    period_end_n = 1'b0;
    pwm_n        = polarity;
    last         = WIDTH'(period_s - 1'b1);

    // P=0 keeps reloading so that a new nonzero period can take effect
    load = !pwm_en || period_end || (period_s == '0);

    if (load) begin
      period_n = period_reg;
      mode_n   = center_mode;
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_n[i] = DC_sel[i] ? i_DC[i*WIDTH +: WIDTH] : DC_reg[i*WIDTH +: WIDTH];
      end
    end

    // A reload always restarts the counter at 0 counting up
    if (pwm_en && !load) begin
      if (!mode_s) begin
        counter_n = (counter == last) ? '0 : WIDTH'(counter + 1'b1);
      end else if (!dir_down) begin
        if (counter == last) begin
          counter_n  = counter;
          dir_down_n = 1'b1;
        end else begin
          counter_n  = WIDTH'(counter + 1'b1);
        end
      end else begin
        if (counter == '0) begin
          counter_n  = '0;
          dir_down_n = 1'b0;
        end else begin
          counter_n  = WIDTH'(counter - 1'b1);
          dir_down_n = 1'b1;
        end
      end
    end

    if (pwm_en) begin
      period_end_n = is_end(counter_n, dir_down_n, period_n, mode_n);
      for (int unsigned i = 0; i < NCH; i++) begin
        pwm_n[i] = ((period_s != '0) && (counter < duty_s[i])) ^ polarity[i];
      end
    end
  end

  // State and output registers
  always_ff @(posedge chosen_clk) begin
    if (rst) begin
      counter    <= '0;
      dir_down   <= 1'b0;
      period_end <= 1'b0;
      pwm        <= polarity;
      period_s   <= '0;
      mode_s     <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        duty_s[i] <= '0;
      end
    end else begin
      counter    <= counter_n;
      dir_down   <= dir_down_n;
      period_end <= period_end_n;
      pwm        <= pwm_n;
      period_s   <= period_n;
      mode_s     <= mode_n;
      duty_s     <= duty_n;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: reset, edge/center modes, shadowing, saturation and P=0.
module tb_pwm_multi_ch;

  logic        clk;
  logic        rst;
  logic        pwm_en;
  logic        center_mode;
  logic [15:0] period_reg;
  logic [63:0] dc_reg;
  logic [63:0] i_dc;
  logic [3:0]  dc_sel;
  logic [3:0]  polarity;
  logic [15:0] counter;
  logic        period_end;
  logic [3:0]  pwm;

  int passed = 0;
  int total  = 0;
  int seq [8] = '{0, 1, 2, 3, 3, 2, 1, 0};
  int hi [4];
  logic [3:0] exp_pwm;
  logic [7:0] t4_pwm0;

  pwm_multi_ch #(.WIDTH(16), .NCH(4)) dut (
    .chosen_clk (clk),
    .rst        (rst),
    .pwm_en     (pwm_en),
    .center_mode(center_mode),
    .period_reg (period_reg),
    .DC_reg     (dc_reg),
    .i_DC       (i_dc),
    .DC_sel     (dc_sel),
    .polarity   (polarity),
    .counter    (counter),
    .period_end (period_end),
    .pwm        (pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; pwm_en = 1'b0; center_mode = 1'b0; period_reg = '0;
    dc_reg = '0; i_dc = '0; dc_sel = '0; polarity = 4'b0101;

    // 1: reset
    tick(); tick();
    check("rst_pwm", 32'(pwm), 32'h5);
    check("rst_cnt", 32'(counter), 32'h0);
    check("rst_pe", 32'(period_end), 32'h0);

    // 2: edge mode, P=6, duties 0,2,3,6
    rst = 1'b0; polarity = 4'b0000; period_reg = 16'd6;
    dc_reg = {16'd6, 16'd3, 16'd2, 16'd0};
    tick();
    check("t2_dis_pwm", 32'(pwm), 32'h0);
    pwm_en = 1'b1;
    hi = '{0, 0, 0, 0};
    for (int k = 1; k <= 14; k++) begin
      tick();
      exp_pwm = {1'b1, ((k - 1) % 6) < 3, ((k - 1) % 6) < 2, 1'b0};
      check($sformatf("t2_cnt_k%0d", k), 32'(counter), 32'(k % 6));
      check($sformatf("t2_pe_k%0d", k), 32'(period_end), 32'((k % 6) == 5));
      check($sformatf("t2_pwm_k%0d", k), 32'(pwm), 32'(exp_pwm));
      if (k >= 7 && k <= 12) begin
        for (int c = 0; c < 4; c++) hi[c] += int'(pwm[c]);
      end
    end
    check("t2_hi0", 32'(hi[0]), 32'd0);
    check("t2_hi1", 32'(hi[1]), 32'd2);
    check("t2_hi2", 32'(hi[2]), 32'd3);
    check("t2_hi3", 32'(hi[3]), 32'd6);

    // pwm_en falling mid-period (counter=2), loading center setup for test 3
    pwm_en = 1'b0; center_mode = 1'b1; period_reg = 16'd4;
    dc_reg = {16'd0, 16'd0, 16'd0, 16'd1};
    tick();
    check("dis_cnt", 32'(counter), 32'h0);
    check("dis_pwm", 32'(pwm), 32'h0);
    check("dis_pe", 32'(period_end), 32'h0);

    // 3: center mode, P=4, D0=1
    pwm_en = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      check($sformatf("t3_cnt_k%0d", k), 32'(counter), 32'(seq[k % 8]));
      check($sformatf("t3_pe_k%0d", k), 32'(period_end), 32'((k % 8) == 7));
      check($sformatf("t3_pwm0_k%0d", k), 32'(pwm[0]), 32'((k % 8) == 0 || (k % 8) == 1));
    end

    // 6: reset mid-run at counter=3
    check("t6_pre_cnt", 32'(counter), 32'd3);
    rst = 1'b1; polarity = 4'b0101;
    tick();
    check("t6_rst_cnt", 32'(counter), 32'h0);
    check("t6_rst_pe", 32'(period_end), 32'h0);
    check("t6_rst_pwm", 32'(pwm), 32'h5);
    rst = 1'b0;
    tick();
    check("t6_r1_cnt", 32'(counter), 32'h0);
    check("t6_r1_pwm", 32'(pwm), 32'h5);
    tick();
    check("t6_r2_cnt", 32'(counter), 32'h1);
    tick();
    check("t6_r3_cnt", 32'(counter), 32'h2);

    // 4: shadow behaviour, edge P=4, D0 1 -> 3 written at counter=1
    pwm_en = 1'b0; center_mode = 1'b0; polarity = 4'b0000;
    dc_reg = {16'd0, 16'd0, 16'd0, 16'd1};
    tick();
    pwm_en = 1'b1;
    t4_pwm0 = 8'b0111_0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        check("t4_cnt_k1", 32'(counter), 32'h1);
        dc_reg = {16'd0, 16'd0, 16'd0, 16'd3};
      end
      check($sformatf("t4_pwm0_k%0d", k), 32'(pwm[0]), 32'(t4_pwm0[k - 1]));
    end

    // 5: P=2, ch1 from i_DC=3 (saturated) inverted; then P=0
    pwm_en = 1'b0; period_reg = 16'd2; dc_reg = '0;
    i_dc = {16'd0, 16'd0, 16'd3, 16'd0}; dc_sel = 4'b0010; polarity = 4'b0010;
    tick();
    pwm_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t5_pwm1_k%0d", k), 32'(pwm[1]), 32'h0);
      check($sformatf("t5_pe_k%0d", k), 32'(period_end), 32'((k % 2) == 1));
    end
    period_reg = 16'd0;
    tick(); tick();
    for (int k = 9; k <= 14; k++) begin
      tick();
      check($sformatf("t5z_pe_k%0d", k), 32'(period_end), 32'h0);
      check($sformatf("t5z_cnt_k%0d", k), 32'(counter), 32'h0);
      check($sformatf("t5z_pwm_k%0d", k), 32'(pwm), 32'h2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
